// File: rtl/ex.sv
// ----------------------------------------------------------------------------
// ex -- execute stage of the five-stage MIPS32 pipeline.
//
// Computes logic, shift, move, arithmetic and multiply results from the
// decoded operation and owns the HI/LO register pair. The registered
// write-back triple (waddr_o/we_o/wdata_o) feeds the memory stage and the
// decode-stage forwarding ports.
//
// Build option:
//   EX_MULT_ITER_EN  defined   : 32-step shift-add multiplier with a small FSM;
//                                stallreq_o holds the front of the pipeline
//                                while a multiply is in flight.
//   EX_MULT_ITER_EN  undefined : single-cycle combinational multiply,
//                                stallreq_o tied low.
//
// Ports:
//   clk        in   pipeline clock, rising edge
//   rst        in   asynchronous, active-high reset
//   alusel_i   in   [2:0]  operation class
//   aluop_i    in   [7:0]  sub-operation
//   reg1_i     in   [31:0] source operand 1 (forwarded or immediate)
//   reg2_i     in   [31:0] source operand 2 (forwarded or immediate)
//   waddr_i    in   [4:0]  destination GPR
//   we_i       in   GPR write request
//   waddr_o    out  [4:0]  registered destination
//   we_o       out  registered GPR write enable
//   wdata_o    out  [31:0] registered result
//   hi_o/lo_o  out  [31:0] current HI/LO contents
//   stallreq_o out  combinational upstream hold request
// ----------------------------------------------------------------------------
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  alusel_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam int DATA_W = 32;

  // Operation classes
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;
  localparam logic [2:0] EXE_RES_MUL   = 3'b101;

  // Sub-operations
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [7:0] EXE_CLZ_OP   = 8'b1011_0000;
  localparam logic [7:0] EXE_CLO_OP   = 8'b1011_0001;

  // Count of leading zero bits, 0..32.
  function automatic logic [5:0] lead_zeros(input logic [DATA_W-1:0] v);
    logic [5:0] n;
    logic       hit;
    n   = 6'd0;
    hit = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i])
        hit = 1'b1;
      else if (!hit)
        n = n + 6'd1;
    end
    return n;
  endfunction

  // Operand magnitude; 0x80000000 maps to 2^31, which is correct as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] apply_sign(input logic [2*DATA_W-1:0] p,
                                                     input logic neg);
    return neg ? (~p + 64'd1) : p;
  endfunction

  logic [4:0]          waddr_p1;
  logic                we_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [DATA_W-1:0]   hi_p1;
  logic [DATA_W-1:0]   lo_p1;

  logic signed [DATA_W:0] sum_ext;
  logic signed [DATA_W:0] dif_ext;
  logic                   add_ovf;
  logic                   sub_ovf;

  logic                   mul_op;
  logic                   mul_signed;
  logic                   mul_neg;
  logic [DATA_W-1:0]      mag_a;
  logic [DATA_W-1:0]      mag_b;
  logic [2*DATA_W-1:0]    mul_prod;

  logic [DATA_W-1:0]      result;
  logic                   we_eff;

  // 33-bit sign-extended add/sub: overflow is a disagreement of the top two bits.
  assign sum_ext = $signed({reg1_i[DATA_W-1], reg1_i}) + $signed({reg2_i[DATA_W-1], reg2_i});
  assign dif_ext = $signed({reg1_i[DATA_W-1], reg1_i}) - $signed({reg2_i[DATA_W-1], reg2_i});
  assign add_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
  assign sub_ovf = dif_ext[DATA_W] ^ dif_ext[DATA_W-1];

  assign mul_op     = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP) ||
                      (aluop_i == EXE_MUL_OP);
  assign mul_signed = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MUL_OP);
  assign mul_neg    = mul_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
  assign mag_a      = magnitude(reg1_i, mul_signed);
  assign mag_b      = magnitude(reg2_i, mul_signed);

`ifdef EX_MULT_ITER_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mstate_t;

  mstate_t             state;
  mstate_t             state_nx;
  logic [2*DATA_W-1:0] mcand_p0;
  logic [2*DATA_W-1:0] acc_p0;
  logic [DATA_W-1:0]   mplier_p0;
  logic [4:0]          count_p0;
  logic                neg_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (mul_op) state_nx = S_BUSY;
      S_BUSY:  if (count_p0 == 5'd31) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---- multiplier iteration stage: one shift-add step per BUSY cycle ----
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (mul_op) begin
        mcand_p0  <= {32'd0, mag_a};
        mplier_p0 <= mag_b;
        acc_p0    <= '0;
        count_p0  <= 5'd0;
        neg_p0    <= mul_neg;
      end
    end else if (state == S_BUSY) begin
      if (mplier_p0[0])
        acc_p0 <= acc_p0 + mcand_p0;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      count_p0  <= count_p0 + 5'd1;
    end
  end

  assign mul_prod   = apply_sign(acc_p0, neg_p0);
  // Released in DONE so the finished product registers at the end of that cycle.
  assign stallreq_o = !rst && mul_op && (state != S_DONE);
`else
  assign mul_prod   = apply_sign({32'd0, mag_a} * {32'd0, mag_b}, mul_neg);
  assign stallreq_o = 1'b0;
`endif

  always_comb begin
    result = '0;
    we_eff = we_i;
    case (alusel_i)
      EXE_RES_NOP: result = '0;
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_AND_OP: result = reg1_i & reg2_i;
          EXE_OR_OP:  result = reg1_i | reg2_i;
          EXE_XOR_OP: result = reg1_i ^ reg2_i;
          EXE_NOR_OP: result = ~(reg1_i | reg2_i);
          default:    result = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP: result = reg2_i << reg1_i[4:0];
          EXE_SRL_OP: result = reg2_i >> reg1_i[4:0];
          EXE_SRA_OP: result = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default:    result = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MOVZ_OP, EXE_MOVN_OP: result = reg1_i;
          EXE_MFHI_OP:              result = hi_p1;
          EXE_MFLO_OP:              result = lo_p1;
          default:                  result = '0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (aluop_i)
          EXE_ADD_OP, EXE_ADDU_OP: result = sum_ext[DATA_W-1:0];
          EXE_SUB_OP, EXE_SUBU_OP: result = dif_ext[DATA_W-1:0];
          EXE_SLT_OP:  result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
          EXE_SLTU_OP: result = {31'd0, reg1_i < reg2_i};
          EXE_CLZ_OP:  result = {26'd0, lead_zeros(reg1_i)};
          EXE_CLO_OP:  result = {26'd0, lead_zeros(~reg1_i)};
          default:     result = '0;
        endcase
      end
      EXE_RES_MUL: result = mul_prod[DATA_W-1:0];
      default:     result = '0;
    endcase

    // Signed overflow suppresses the write; HI/LO-only ops never write a GPR.
    case (aluop_i)
      EXE_ADD_OP: if (add_ovf) we_eff = 1'b0;
      EXE_SUB_OP: if (sub_ovf) we_eff = 1'b0;
      EXE_MTHI_OP, EXE_MTLO_OP, EXE_MULT_OP, EXE_MULTU_OP: we_eff = 1'b0;
      default: ;
    endcase
  end

  // ---- EX/MEM boundary: write-back triple and HI/LO ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_p1 <= '0;
      we_p1    <= 1'b0;
      wdata_p1 <= '0;
      hi_p1    <= '0;
      lo_p1    <= '0;
    end else if (stallreq_o) begin
      waddr_p1 <= '0;
      we_p1    <= 1'b0;
      wdata_p1 <= '0;
    end else begin
      waddr_p1 <= waddr_i;
      we_p1    <= we_eff;
      wdata_p1 <= result;
      case (aluop_i)
        EXE_MTHI_OP:               hi_p1 <= reg1_i;
        EXE_MTLO_OP:               lo_p1 <= reg1_i;
        EXE_MULT_OP, EXE_MULTU_OP: {hi_p1, lo_p1} <= mul_prod;
        default: ;
      endcase
    end
  end

  assign waddr_o = waddr_p1;
  assign we_o    = we_p1;
  assign wdata_o = wdata_p1;
  assign hi_o    = hi_p1;
  assign lo_o    = lo_p1;

endmodule
